// File: rtl/uart_to_bram_pkg.sv
// Shared constants and RX state encodings for the UART-to-BRAM loader.
package uart_to_bram_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam int BYTES_PER_WORD  = 4;
    localparam int IDLE_FLUSH_BITS = 16;

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, bit timer and RX FSM.
// Exposes an idle indication only when UART_TO_BRAM_IDLE_FLUSH_EN is defined.
module uart_rx
    import uart_to_bram_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
`ifdef UART_TO_BRAM_IDLE_FLUSH_EN
    output logic       rx_idle,
`endif
    output logic       rx_ferr
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);

    logic            sync1_q, sync2_q;
    rx_state_e       state_q;
    logic [TW-1:0]   timer_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            valid_q, ferr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    // Timer restarts on every state change so each sample lands mid-bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RX_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (!sync2_q) begin
                        state_q <= RX_START;
                        timer_q <= '0;
                    end
                end
                RX_START: begin
                    if (timer_q == HALF_LAST) begin
                        timer_q   <= '0;
                        bit_idx_q <= '0;
                        state_q   <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (timer_q == FULL_LAST) begin
                        timer_q   <= '0;
                        shift_q   <= {sync2_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (timer_q == FULL_LAST) begin
                        timer_q <= '0;
                        valid_q <= sync2_q;
                        ferr_q  <= !sync2_q;
                        state_q <= RX_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_byte  = shift_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;
`ifdef UART_TO_BRAM_IDLE_FLUSH_EN
    assign rx_idle  = (state_q == RX_IDLE);
`endif

endmodule

// File: rtl/uart_to_bram.sv
// Loads BRAM from a UART byte stream, packing bytes little-endian into words.
// Optional partial-word flush on line idle: UART_TO_BRAM_IDLE_FLUSH_EN.
module uart_to_bram
    import uart_to_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    output logic                  done,
    output logic                  frame_err,
    output logic [ADDR_WIDTH+1:0] byte_cnt_total
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_ferr;

    logic [1:0]            lane_q, lane_d;
    logic [DATA_WIDTH-1:0] word_q, word_d, merged;
    logic [ADDR_WIDTH+1:0] byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;

`ifdef UART_TO_BRAM_IDLE_FLUSH_EN
    localparam int FLUSH_CYCLES = IDLE_FLUSH_BITS * CLKS_PER_BIT;
    localparam int IW = $clog2(FLUSH_CYCLES);
    localparam logic [IW-1:0] FLUSH_LAST = IW'(FLUSH_CYCLES - 1);
    logic          rx_idle;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
`endif

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .rx_in   (uart_rx),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
`ifdef UART_TO_BRAM_IDLE_FLUSH_EN
        .rx_idle (rx_idle),
`endif
        .rx_ferr (rx_ferr)
    );

    // Word buffer is cleared after every write so a flushed partial word has zero upper lanes.
    always_comb begin
        lane_d     = lane_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        done_d     = done_q;
        ferr_d     = ferr_q | (rx_ferr & ~done_q);
        merged     = word_q;
        merged[{lane_q, 3'b000} +: 8] = rx_byte;

        if (we_q) begin
            if (addr_q == LAST_ADDR) begin
                done_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end

        if (rx_valid && !done_q) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (lane_q == LAST_LANE) begin
                we_d    = 1'b1;
                wdata_d = merged;
                word_d  = '0;
                lane_d  = '0;
            end else begin
                word_d = merged;
                lane_d = lane_q + 1'b1;
            end
        end

`ifdef UART_TO_BRAM_IDLE_FLUSH_EN
        idle_cnt_d = '0;
        if (!done_q && rx_idle && lane_q != 2'd0 && !rx_valid) begin
            if (idle_cnt_q == FLUSH_LAST) begin
                we_d    = 1'b1;
                wdata_d = word_q;
                word_d  = '0;
                lane_d  = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q     <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_TO_BRAM_IDLE_FLUSH_EN
            idle_cnt_q <= '0;
`endif
        end else begin
            lane_q     <= lane_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
`ifdef UART_TO_BRAM_IDLE_FLUSH_EN
            idle_cnt_q <= idle_cnt_d;
`endif
        end
    end

    assign bram_we        = we_q;
    assign bram_addr      = addr_q;
    assign bram_wdata     = wdata_q;
    assign done           = done_q;
    assign frame_err      = ferr_q;
    assign byte_cnt_total = byte_cnt_q;

endmodule

// File: tb/tb_uart_to_bram.sv
// Self-checking bench for uart_to_bram: directed scenarios plus randomized frames vs a byte-level model.
// Exercises the idle flush when UART_TO_BRAM_IDLE_FLUSH_EN is defined, otherwise checks that partial words wait.
module tb_uart_to_bram;

    localparam int AW  = 2;
    localparam int DW  = 32;
    localparam int CF  = 1_000_000;
    localparam int BR  = 100_000;
    localparam int CPB = CF / BR;
    localparam int CNT_MOD = 2 ** (AW + 2);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          uart_rx = 1'b1;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic          done;
    logic          frame_err;
    logic [AW+1:0] byte_cnt_total;

    int n_cmp  = 0;
    int n_fail = 0;
    int cycle  = 0;
    int last_start = 0;

    uart_to_bram #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_FREQ(CF), .BAUD_RATE(BR)
    ) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .done(done),
        .frame_err(frame_err), .byte_cnt_total(byte_cnt_total)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Observed BRAM writes, sampled on the falling edge.
    logic [AW-1:0] obs_addr[$];
    logic [DW-1:0] obs_data[$];
    int            obs_cyc[$];
    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            obs_addr.push_back(bram_addr);
            obs_data.push_back(bram_wdata);
            obs_cyc.push_back(cycle);
        end
    end

    // Reference model: good bytes fill a word from the low byte up; each full word goes to the next address.
    int              m_lane, m_count, m_addr;
    bit              m_done, m_ferr;
    longint unsigned m_word;
    logic [AW-1:0]   exp_addr[$];
    logic [DW-1:0]   exp_data[$];

    task automatic model_reset();
        m_lane = 0; m_count = 0; m_addr = 0; m_done = 0; m_ferr = 0; m_word = 0;
        exp_addr.delete(); exp_data.delete();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (m_done) return;
        if (!good) begin
            m_ferr = 1;
            return;
        end
        m_word  = m_word + (longint'(b) * (longint'(1) << (8 * m_lane)));
        m_count = m_count + 1;
        m_lane  = m_lane + 1;
        if (m_lane == 4) begin
            exp_addr.push_back(AW'(m_addr));
            exp_data.push_back(DW'(m_word));
            if (m_addr == 2 ** AW - 1) m_done = 1;
            else m_addr = m_addr + 1;
            m_lane = 0;
            m_word = 0;
        end
    endtask

    // Called and returning at a falling edge; frames are contiguous when called back to back.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        last_start = cycle;
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        send_frame(b, good ? 1'b1 : 1'b0);
        model_byte(b, good);
        if (!good) repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (bram_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we: got %b want 0", bram_we); end
        n_cmp++; if (bram_addr !== '0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h want 0", bram_addr); end
        n_cmp++; if (bram_wdata !== '0) begin n_fail++; $display("[TB] FAIL reset_wdata: got %h want 0", bram_wdata); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ferr: got %b want 0", frame_err); end
        n_cmp++; if (byte_cnt_total !== '0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d want 0", byte_cnt_total); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_word();
        logic [7:0] bytes[4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        int lat;
        do_reset();
        foreach (bytes[i]) send_byte(bytes[i], 1);
        repeat (10) @(negedge clk);
        n_cmp++; if (obs_data.size() != 1) begin n_fail++; $display("[TB] FAIL single_count: got %0d writes want 1", obs_data.size()); end
        if (obs_data.size() >= 1) begin
            lat = obs_cyc[0] - last_start;
            n_cmp++; if (obs_addr[0] !== 2'd0) begin n_fail++; $display("[TB] FAIL single_addr: got %0d want 0", obs_addr[0]); end
            n_cmp++; if (obs_data[0] !== 32'h11223344) begin n_fail++; $display("[TB] FAIL single_data: got %h want 11223344", obs_data[0]); end
            n_cmp++; if (lat < 95 || lat > 101) begin n_fail++; $display("[TB] FAIL single_latency: got %0d clk from last start bit want 95..101", lat); end
        end
        n_cmp++; if (byte_cnt_total !== 4'd4) begin n_fail++; $display("[TB] FAIL single_cnt: got %0d want 4", byte_cnt_total); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL single_done: got %b want 0", done); end
    endtask

    task automatic test_fill();
        logic [DW-1:0] want[4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1);
        repeat (10) @(negedge clk);
        n_cmp++; if (obs_data.size() != 4) begin n_fail++; $display("[TB] FAIL fill_count: got %0d writes want 4", obs_data.size()); end
        for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
            n_cmp++; if (obs_addr[i] !== AW'(i)) begin n_fail++; $display("[TB] FAIL fill_addr%0d: got %0d want %0d", i, obs_addr[i], i); end
            n_cmp++; if (obs_data[i] !== want[i]) begin n_fail++; $display("[TB] FAIL fill_data%0d: got %h want %h", i, obs_data[i], want[i]); end
        end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_done: got %b want 1", done); end
        n_cmp++; if (bram_addr !== 2'd3) begin n_fail++; $display("[TB] FAIL fill_ptr_hold: got %0d want 3", bram_addr); end
        send_byte(8'h10, 1);
        repeat (10) @(negedge clk);
        n_cmp++; if (obs_data.size() != 4) begin n_fail++; $display("[TB] FAIL fill_extra_write: got %0d writes want 4", obs_data.size()); end
        n_cmp++; if (byte_cnt_total !== 4'(16 % CNT_MOD)) begin n_fail++; $display("[TB] FAIL fill_cnt_frozen: got %0d want %0d", byte_cnt_total, 16 % CNT_MOD); end
    endtask

    task automatic test_framing();
        do_reset();
        send_byte(8'hAA, 0);
        n_cmp++; if (frame_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ferr_flag: got %b want 1", frame_err); end
        n_cmp++; if (byte_cnt_total !== 4'd0) begin n_fail++; $display("[TB] FAIL ferr_cnt: got %0d want 0", byte_cnt_total); end
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1);
        repeat (10) @(negedge clk);
        n_cmp++; if (obs_data.size() != 1) begin n_fail++; $display("[TB] FAIL ferr_count: got %0d writes want 1", obs_data.size()); end
        if (obs_data.size() >= 1) begin
            n_cmp++; if (obs_data[0] !== 32'h04030201) begin n_fail++; $display("[TB] FAIL ferr_data: got %h want 04030201", obs_data[0]); end
        end
        n_cmp++; if (frame_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ferr_sticky: got %b want 1", frame_err); end
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        do_reset();
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (5 * CPB) @(negedge clk);
        n_cmp++; if (byte_cnt_total !== 4'd0) begin n_fail++; $display("[TB] FAIL glitch_cnt: got %0d want 0", byte_cnt_total); end
        n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_ferr: got %b want 0", frame_err); end
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send_byte(b, 1);
        end
        repeat (10) @(negedge clk);
        n_cmp++; if (obs_data.size() != 1 || exp_data.size() != 1) begin n_fail++; $display("[TB] FAIL glitch_recover_count: got %0d writes want 1", obs_data.size()); end
        else begin
            n_cmp++; if (obs_data[0] !== exp_data[0]) begin n_fail++; $display("[TB] FAIL glitch_recover_data: got %h want %h", obs_data[0], exp_data[0]); end
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        send_byte(8'($urandom), 1);
        send_byte(8'($urandom), 1);
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 1);
        repeat (10) @(negedge clk);
        n_cmp++; if (obs_data.size() != 1) begin n_fail++; $display("[TB] FAIL midrst_count: got %0d writes want 1", obs_data.size()); end
        if (obs_data.size() >= 1) begin
            n_cmp++; if (obs_addr[0] !== 2'd0) begin n_fail++; $display("[TB] FAIL midrst_addr: got %0d want 0", obs_addr[0]); end
            n_cmp++; if (obs_data[0] !== 32'hA3A2A1A0) begin n_fail++; $display("[TB] FAIL midrst_data: got %h want A3A2A1A0", obs_data[0]); end
        end
        n_cmp++; if (byte_cnt_total !== 4'd4) begin n_fail++; $display("[TB] FAIL midrst_cnt: got %0d want 4", byte_cnt_total); end
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 22; f++) begin
            send_byte(8'($urandom), $urandom_range(0, 5) != 0);
            repeat ($urandom_range(0, 2 * CPB)) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        n_cmp++; if (obs_data.size() != exp_data.size()) begin n_fail++; $display("[TB] FAIL rand_count: got %0d writes want %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            n_cmp++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                n_fail++; $display("[TB] FAIL rand_write%0d: got %0d:%h want %0d:%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++; if (byte_cnt_total !== 4'(m_count % CNT_MOD)) begin n_fail++; $display("[TB] FAIL rand_cnt: got %0d want %0d", byte_cnt_total, m_count % CNT_MOD); end
        n_cmp++; if (frame_err !== m_ferr) begin n_fail++; $display("[TB] FAIL rand_ferr: got %b want %b", frame_err, m_ferr); end
        n_cmp++; if (done !== m_done) begin n_fail++; $display("[TB] FAIL rand_done: got %b want %b", done, m_done); end
    endtask

`ifdef UART_TO_BRAM_IDLE_FLUSH_EN
    task automatic test_flush();
        do_reset();
        send_byte(8'h55, 1);
        send_byte(8'h66, 1);
        repeat (200) @(negedge clk);
        n_cmp++; if (obs_data.size() != 1) begin n_fail++; $display("[TB] FAIL flush_count: got %0d writes want 1", obs_data.size()); end
        if (obs_data.size() >= 1) begin
            n_cmp++; if (obs_addr[0] !== 2'd0) begin n_fail++; $display("[TB] FAIL flush_addr: got %0d want 0", obs_addr[0]); end
            n_cmp++; if (obs_data[0] !== 32'h00006655) begin n_fail++; $display("[TB] FAIL flush_data: got %h want 00006655", obs_data[0]); end
        end
        n_cmp++; if (byte_cnt_total !== 4'd2) begin n_fail++; $display("[TB] FAIL flush_cnt: got %0d want 2", byte_cnt_total); end
    endtask
`else
    task automatic test_no_flush();
        do_reset();
        send_byte(8'h55, 1);
        send_byte(8'h66, 1);
        repeat (200) @(negedge clk);
        n_cmp++; if (obs_data.size() != 0) begin n_fail++; $display("[TB] FAIL noflush_idle: got %0d writes want 0", obs_data.size()); end
        send_byte(8'h77, 1);
        send_byte(8'h88, 1);
        repeat (10) @(negedge clk);
        n_cmp++; if (obs_data.size() != 1) begin n_fail++; $display("[TB] FAIL noflush_count: got %0d writes want 1", obs_data.size()); end
        if (obs_data.size() >= 1) begin
            n_cmp++; if (obs_data[0] !== 32'h88776655) begin n_fail++; $display("[TB] FAIL noflush_data: got %h want 88776655", obs_data[0]); end
        end
    endtask
`endif

    initial begin
        $display("[TB] uart_to_bram bench start, %0d clk per bit", CPB);
        test_reset();
        test_single_word();
        test_fill();
        test_framing();
        test_glitch();
        test_reset_mid_word();
        test_random();
        test_random();
`ifdef UART_TO_BRAM_IDLE_FLUSH_EN
        test_flush();
`else
        test_no_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
